// File: rtl/cbp_pipelined_subtractor_pkg.sv
// Shared types and constants for the pipelined carry-bypass subtractor.
// One stage register per bypass group; operands skew forward as groups are consumed.
package cbp_pipelined_subtractor_pkg;

    localparam int CBP_NUM_BITS   = 32;
    localparam int CBP_NUM_STAGES = 4;
    localparam int CBP_G          = CBP_NUM_BITS / CBP_NUM_STAGES;
    localparam bit CBP_WIDTH_OK   = (CBP_NUM_BITS % CBP_NUM_STAGES) == 0;

    typedef struct packed {
        logic                    valid;
        logic                    carry;
        logic [CBP_NUM_BITS-1:0] a_rem;
        logic [CBP_NUM_BITS-1:0] nb_rem;
        logic [CBP_NUM_BITS-1:0] diff_done;
        logic                    a_msb;
        logic                    b_msb;
    } stage_t;

    // Keeps only the operand groups not yet consumed after stage k.
    function automatic logic [CBP_NUM_BITS-1:0] upper_mask(input int k);
        if ((k + 1) * CBP_G >= CBP_NUM_BITS)
            return '0;
        return {CBP_NUM_BITS{1'b1}} << ((k + 1) * CBP_G);
    endfunction

endpackage

// File: rtl/cbp_sub_group.sv
// Combinational G-bit ripple group with a group-propagate bypass of the carry.
// Operands arrive as a and ~b, so this is an adder slice of A + ~B + 1.
module cbp_sub_group
    import cbp_pipelined_subtractor_pkg::*;
#(
    parameter int G = CBP_G
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] nb,
    input  logic         cin,
    output logic [G-1:0] sum,
    output logic         cout
);

    logic [G-1:0] p;
    logic         ripple_cout;
    logic         group_p;

    assign p       = a ^ nb;
    assign group_p = &p;

    // NOTE: blocking assignments are correct in combinational logic; c is a
    // running value and each loop step must see the previous step's result.
    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < G; i++) begin
            sum[i] = p[i] ^ c;
            c      = (a[i] & nb[i]) | (p[i] & c);
        end
        ripple_cout = c;
    end

    // When every bit propagates the carry-in passes straight through.
    assign cout = group_p ? cin : ripple_cout;

endmodule

// File: rtl/cbp_pipelined_subtractor.sv
// Pipelined A - B with one carry-bypass group per stage and a global stall.
// All registers and the valid/ready handshake live here; groups are combinational.
module cbp_pipelined_subtractor
    import cbp_pipelined_subtractor_pkg::*;
#(
    parameter int NUM_BITS   = CBP_NUM_BITS,
    parameter int NUM_STAGES = CBP_NUM_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] Diff,
    output logic                Borrow,
    output logic                Overflow
);

    localparam int G    = NUM_BITS / NUM_STAGES;
    localparam int LAST = NUM_STAGES - 1;
    localparam int MSB  = NUM_BITS - 1;

    if (NUM_BITS != CBP_NUM_BITS || NUM_STAGES != CBP_NUM_STAGES || !CBP_WIDTH_OK
        || (NUM_BITS % NUM_STAGES) != 0) begin : g_bad_cfg
        $error("cbp_pipelined_subtractor: NUM_BITS must be a multiple of NUM_STAGES and match the package");
    end

    stage_t       st        [NUM_STAGES];
    stage_t       src_stage [NUM_STAGES];
    stage_t       nxt       [NUM_STAGES];
    logic [G-1:0] grp_a     [NUM_STAGES];
    logic [G-1:0] grp_nb    [NUM_STAGES];
    logic [G-1:0] grp_sum   [NUM_STAGES];
    logic         grp_cin   [NUM_STAGES];
    logic         grp_cout  [NUM_STAGES];
    logic         advance;

    assign advance  = !st[LAST].valid || out_ready;
    assign in_ready = advance;

    // Stage 0 consumes the raw operands; later stages consume the previous register.
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        src_stage[0]           = '0;
        src_stage[0].valid     = in_valid && advance;
        src_stage[0].carry     = 1'b1;
        src_stage[0].a_rem     = A;
        src_stage[0].nb_rem    = ~B;
        src_stage[0].a_msb     = A[MSB];
        src_stage[0].b_msb     = B[MSB];
        for (int k = 1; k < NUM_STAGES; k++)
            src_stage[k] = st[k-1];
        for (int k = 0; k < NUM_STAGES; k++) begin
            grp_a[k]   = src_stage[k].a_rem[k*G +: G];
            grp_nb[k]  = src_stage[k].nb_rem[k*G +: G];
            grp_cin[k] = src_stage[k].carry;
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_group
        cbp_sub_group #(.G(G)) u_group (
            .a    (grp_a[k]),
            .nb   (grp_nb[k]),
            .cin  (grp_cin[k]),
            .sum  (grp_sum[k]),
            .cout (grp_cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            nxt[k]                      = src_stage[k];
            nxt[k].carry                = grp_cout[k];
            nxt[k].a_rem                = src_stage[k].a_rem & upper_mask(k);
            nxt[k].nb_rem               = src_stage[k].nb_rem & upper_mask(k);
            nxt[k].diff_done[k*G +: G]  = grp_sum[k];
        end
    end

    // NOTE: non-blocking assignments so every stage samples its predecessor's
    // pre-edge value. Data fields are reset too, so outputs read zero, not X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++)
                st[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k < NUM_STAGES; k++)
                st[k] <= nxt[k];
        end
    end

    // Flags are gated by valid so an idle output reads all zeros.
    assign out_valid = st[LAST].valid;
    assign Diff      = st[LAST].diff_done;
    assign Borrow    = st[LAST].valid & ~st[LAST].carry;
    assign Overflow  = st[LAST].valid & (st[LAST].a_msb ^ st[LAST].b_msb)
                     & (st[LAST].diff_done[MSB] ^ st[LAST].a_msb);

endmodule
